// File: rtl/mem_pkg.sv
// Shared FUNC3 codes, FSM state encoding and load-extension helper for the
// MEM stage.
package mem_pkg;

   localparam logic [2:0] Func3Lb  = 3'b000;
   localparam logic [2:0] Func3Lh  = 3'b001;
   localparam logic [2:0] Func3Lw  = 3'b010;
   localparam logic [2:0] Func3Lbu = 3'b100;
   localparam logic [2:0] Func3Lhu = 3'b101;
   localparam logic [2:0] Func3Sb  = 3'b000;
   localparam logic [2:0] Func3Sh  = 3'b001;
   localparam logic [2:0] Func3Sw  = 3'b010;

   typedef enum logic {StIdle, StBusy} state_e;

   // Picks the addressed byte/half-word out of a little-endian word and extends it.
   function automatic logic [31:0] load_extend(input logic [2:0]  func3,
                                               input logic [31:0] word,
                                               input logic [1:0]  lane);
      logic [7:0]  byte_v;
      logic [15:0] half_v;
      logic [31:0] res;
      byte_v = word[{lane, 3'b000} +: 8];
      half_v = word[{lane[1], 4'b0000} +: 16];
      case (func3)
         Func3Lb:  res = {{24{byte_v[7]}}, byte_v};
         Func3Lh:  res = {{16{half_v[15]}}, half_v};
         Func3Lw:  res = word;
         Func3Lbu: res = {24'd0, byte_v};
         Func3Lhu: res = {16'd0, half_v};
         default:  res = 32'd0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/data_mem_array.sv
// Word-organised data memory: byte-enable synchronous write, combinational read.
module data_mem_array #(
   parameter int unsigned Depth = 256,
   parameter int unsigned AddrW = $clog2(Depth)
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [3:0]       be_i,
   input  logic [AddrW-1:0] addr_i,
   input  logic [31:0]      wdata_i,
   output logic [31:0]      rdata_o
);

   logic [31:0] mem_q [Depth];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int b = 0; b < 4; b++) begin
            if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
         end
      end
   end

   assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_access_unit.sv
// RV32IM MEM stage: sized loads/stores with wait-state stall and registered WB outputs.
// Define MEM_MISALIGN_TRAP_EN to flag misaligned accesses instead of aligning them.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [2:0]  EX_FUNC3,
   input  logic        EX_WRITE_ENABLE,
   input  logic        EX_DATA_MEM_SELECT,
   input  logic        EX_MEM_WRITE,
   input  logic        EX_MEM_READ,
   input  logic [31:0] EX_JAL_SELECTED,
   input  logic [31:0] EX_READ_DATA2,
   input  logic [4:0]  EX_RD,
   output logic [2:0]  MEM_FUNC3,
   output logic        MEM_WRITE_ENABLE,
   output logic        MEM_DATA_MEM_SELECT,
   output logic [31:0] MEM_JAL_SELECTED,
   output logic [31:0] MEM_DATA_OUT,
   output logic [4:0]  MEM_RD,
   output logic        MEM_STALL,
   output logic        MEM_MISALIGN
);

   localparam int unsigned AddrW   = $clog2(DEPTH_WORDS);
   localparam logic [3:0]  WaitCnt = 4'(WAIT_STATES);
   localparam logic        HasWait = (WAIT_STATES != 0);

   logic             req, is_load, is_store, is_half, is_word, mis, stall, complete;
   logic [1:0]       lane;
   logic [3:0]       be;
   logic [31:0]      wdata, rdata;
   logic [AddrW-1:0] word_idx;

   assign req      = EX_MEM_READ | EX_MEM_WRITE;
   assign is_store = EX_MEM_WRITE;
   assign is_load  = EX_MEM_READ & ~EX_MEM_WRITE;
   assign is_half  = (EX_FUNC3 == Func3Sh) | (is_load & (EX_FUNC3 == Func3Lhu));
   assign is_word  = (EX_FUNC3 == Func3Sw);
   assign word_idx = EX_JAL_SELECTED[AddrW+1:2];

`ifdef MEM_MISALIGN_TRAP_EN
   assign mis  = req & ((is_half & EX_JAL_SELECTED[0]) | (is_word & (|EX_JAL_SELECTED[1:0])));
   assign lane = EX_JAL_SELECTED[1:0];
`else
   assign mis  = 1'b0;
   // Clearing the offending low bits aligns the access onto its natural boundary.
   assign lane = is_word ? 2'b00 : (is_half ? {EX_JAL_SELECTED[1], 1'b0} : EX_JAL_SELECTED[1:0]);
`endif

   always_comb begin
      be    = 4'b0000;
      wdata = EX_READ_DATA2;
      case (EX_FUNC3)
         Func3Sb: begin
            be    = 4'b0001 << lane;
            wdata = {4{EX_READ_DATA2[7:0]}};
         end
         Func3Sh: begin
            be    = lane[1] ? 4'b1100 : 4'b0011;
            wdata = {2{EX_READ_DATA2[15:0]}};
         end
         Func3Sw: be = 4'b1111;
         default: be = 4'b0000;
      endcase
   end

   // FSM: state register, next state, stall output.
   state_e     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (req && HasWait && !mis) begin
               state_d = StBusy;
               cnt_d   = 4'd1;
            end
         end
         StBusy: begin
            if (cnt_q == WaitCnt) begin
               state_d = StIdle;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = 4'd0;
         end
      endcase
   end

   always_comb begin
      stall = 1'b0;
      if (req && HasWait && !mis) stall = !((state_q == StBusy) && (cnt_q == WaitCnt));
   end

   assign MEM_STALL = stall;
   assign complete  = req & ~stall;

   data_mem_array #(
      .Depth (DEPTH_WORDS),
      .AddrW (AddrW)
   ) u_data_mem_array (
      .clk_i   (CLK),
      .we_i    (complete & is_store & ~mis & RST),
      .be_i    (be),
      .addr_i  (word_idx),
      .wdata_i (wdata),
      .rdata_o (rdata)
   );

   logic [2:0]  func3_q;
   logic        wen_q, dsel_q, mis_q;
   logic [31:0] jal_q, data_q;
   logic [4:0]  rd_q;

   // Registers only move when not stalled, which for req=0 means every cycle.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         func3_q <= 3'd0;
         wen_q   <= 1'b0;
         dsel_q  <= 1'b0;
         jal_q   <= 32'd0;
         data_q  <= 32'd0;
         rd_q    <= 5'd0;
         mis_q   <= 1'b0;
      end else if (!stall) begin
         func3_q <= EX_FUNC3;
         wen_q   <= EX_WRITE_ENABLE & ~mis;
         dsel_q  <= EX_DATA_MEM_SELECT;
         jal_q   <= EX_JAL_SELECTED;
         data_q  <= (is_load && !mis) ? load_extend(EX_FUNC3, rdata, lane) : 32'd0;
         rd_q    <= EX_RD;
         mis_q   <= mis;
      end
   end

   assign MEM_FUNC3           = func3_q;
   assign MEM_WRITE_ENABLE    = wen_q;
   assign MEM_DATA_MEM_SELECT = dsel_q;
   assign MEM_JAL_SELECTED    = jal_q;
   assign MEM_DATA_OUT        = data_q;
   assign MEM_RD              = rd_q;
   assign MEM_MISALIGN        = mis_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with WAIT_STATES of 0, 2 and 3.
module tb_mem_access_unit;

`ifdef MEM_MISALIGN_TRAP_EN
   localparam bit TrapEn = 1'b1;
`else
   localparam bit TrapEn = 1'b0;
`endif

   typedef struct {
      logic [31:0] data;
      logic        we;
      logic        mis;
      logic [4:0]  rd;
      logic [31:0] jal;
      logic [2:0]  f3;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst  [3];
   logic [2:0]  f3   [3];
   logic        wen  [3];
   logic        dsel [3];
   logic        mw   [3];
   logic        mr   [3];
   logic [31:0] jal  [3];
   logic [31:0] rd2  [3];
   logic [4:0]  rdx  [3];
   logic [2:0]  o_f3   [3];
   logic        o_we   [3];
   logic        o_dsel [3];
   logic [31:0] o_jal  [3];
   logic [31:0] o_data [3];
   logic [4:0]  o_rd   [3];
   logic        o_stall[3];
   logic        o_mis  [3];

   exp_t       sb_q[$];
   int         n_run  = 0;
   int         n_fail = 0;
   logic [4:0] rd_ctr = 5'd1;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      mem_access_unit #(
         .DEPTH_WORDS (64),
         .WAIT_STATES (g == 0 ? 0 : (g == 1 ? 2 : 3))
      ) u_dut (
         .CLK                 (clk),
         .RST                 (rst[g]),
         .EX_FUNC3            (f3[g]),
         .EX_WRITE_ENABLE     (wen[g]),
         .EX_DATA_MEM_SELECT  (dsel[g]),
         .EX_MEM_WRITE        (mw[g]),
         .EX_MEM_READ         (mr[g]),
         .EX_JAL_SELECTED     (jal[g]),
         .EX_READ_DATA2       (rd2[g]),
         .EX_RD               (rdx[g]),
         .MEM_FUNC3           (o_f3[g]),
         .MEM_WRITE_ENABLE    (o_we[g]),
         .MEM_DATA_MEM_SELECT (o_dsel[g]),
         .MEM_JAL_SELECTED    (o_jal[g]),
         .MEM_DATA_OUT        (o_data[g]),
         .MEM_RD              (o_rd[g]),
         .MEM_STALL           (o_stall[g]),
         .MEM_MISALIGN        (o_mis[g])
      );
   end

   function automatic int ws_of(input int d);
      return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // Presents one op, waits for its completion edge, then checks against the scoreboard.
   task automatic do_op(input int d, input bit ld, input bit st, input logic [2:0] func3,
                        input logic [31:0] addr, input logic [31:0] wdat,
                        input logic [31:0] exp_data, input bit mis, input string tag);
      exp_t e;
      int   stalls;
      int   exp_st;
      bit   done;
      f3[d]   = func3;
      wen[d]  = ld | ~(ld | st);
      dsel[d] = ld;
      mw[d]   = st;
      mr[d]   = ld;
      jal[d]  = addr;
      rd2[d]  = wdat;
      rdx[d]  = rd_ctr;
      e.data  = (ld && !st) ? exp_data : 32'd0;
      e.we    = ld | ~(ld | st);
      e.mis   = 1'b0;
      e.rd    = rd_ctr;
      e.jal   = addr;
      e.f3    = func3;
      exp_st  = (ld || st) ? ws_of(d) : 0;
      if (TrapEn && mis) begin
         e.data = 32'd0;
         e.we   = 1'b0;
         e.mis  = 1'b1;
         exp_st = 0;
      end
      sb_q.push_back(e);
      rd_ctr++;
      #1;
      stalls = 0;
      done   = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         if (o_stall[d]) stalls++;
         else done = 1'b1;
         @(posedge clk);
         #1;
      end
      if (!done) check({tag, "/timeout"}, 32'd0, 32'd1);
      e = sb_q.pop_front();
      check({tag, "/data"}, o_data[d], e.data);
      check({tag, "/we"}, 32'(o_we[d]), 32'(e.we));
      check({tag, "/mis"}, 32'(o_mis[d]), 32'(e.mis));
      check({tag, "/rd"}, 32'(o_rd[d]), 32'(e.rd));
      check({tag, "/jal"}, o_jal[d], e.jal);
      check({tag, "/f3"}, 32'(o_f3[d]), 32'(e.f3));
      check({tag, "/stalls"}, 32'(stalls), 32'(exp_st));
   endtask

   initial begin
      for (int d = 0; d < 3; d++) begin
         rst[d] = 1'b0; f3[d] = 3'd0; wen[d] = 1'b0; dsel[d] = 1'b0;
         mw[d] = 1'b0; mr[d] = 1'b0; jal[d] = 32'd0; rd2[d] = 32'd0; rdx[d] = 5'd0;
      end
      // Drive non-zero EX values during reset so a leaky register shows up.
      #1;
      for (int d = 0; d < 3; d++) begin
         jal[d] = 32'hFFFF_FFFF; rdx[d] = 5'd31; wen[d] = 1'b1; dsel[d] = 1'b1; f3[d] = 3'd7;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         check($sformatf("rst%0d/data", d), o_data[d], 32'd0);
         check($sformatf("rst%0d/jal", d), o_jal[d], 32'd0);
         check($sformatf("rst%0d/ctl", d),
               32'({o_f3[d], o_we[d], o_dsel[d], o_rd[d], o_mis[d], o_stall[d]}), 32'd0);
         rst[d] = 1'b1;
      end

      // W=0 instance
      do_op(0, 0, 1, 3'b010, 32'h10, 32'h0, 32'h0, 0, "sw_clr10");
      do_op(0, 0, 1, 3'b010, 32'h14, 32'h0, 32'h0, 0, "sw_clr14");
      do_op(0, 0, 1, 3'b010, 32'h18, 32'hDEADBEEF, 32'h0, 0, "sw18");
      do_op(0, 1, 0, 3'b010, 32'h18, 32'h0, 32'hDEADBEEF, 0, "lw18");
      do_op(0, 0, 1, 3'b000, 32'h11, 32'h000000EF, 32'h0, 0, "sb11");
      do_op(0, 1, 0, 3'b000, 32'h11, 32'h0, 32'hFFFFFFEF, 0, "lb11");
      do_op(0, 1, 0, 3'b100, 32'h11, 32'h0, 32'h000000EF, 0, "lbu11");
      do_op(0, 1, 0, 3'b010, 32'h10, 32'h0, 32'h0000EF00, 0, "lw10");
      do_op(0, 0, 1, 3'b001, 32'h16, 32'h00C0BEEF, 32'h0, 0, "sh16");
      do_op(0, 1, 0, 3'b001, 32'h16, 32'h0, 32'hFFFFBEEF, 0, "lh16");
      do_op(0, 1, 0, 3'b101, 32'h16, 32'h0, 32'h0000BEEF, 0, "lhu16");
      do_op(0, 1, 0, 3'b010, 32'h14, 32'h0, 32'hBEEF0000, 0, "lw14");
      do_op(0, 1, 0, 3'b010, 32'h1A, 32'h0, 32'hDEADBEEF, 1, "lw1a_mis");
      do_op(0, 0, 1, 3'b011, 32'h18, 32'hFFFFFFFF, 32'h0, 0, "sbad18");
      do_op(0, 1, 0, 3'b010, 32'h118, 32'h0, 32'hDEADBEEF, 0, "lw_wrap");
      do_op(0, 1, 0, 3'b011, 32'h18, 32'h0, 32'h0, 0, "lbad18");
      do_op(0, 1, 1, 3'b010, 32'h18, 32'h5555AAAA, 32'h0, 0, "rw_both");
      do_op(0, 1, 0, 3'b010, 32'h18, 32'h0, 32'h5555AAAA, 0, "lw_both");
      do_op(0, 0, 0, 3'b000, 32'h12345678, 32'h0, 32'h0, 0, "nop0");
      mr[0] = 1'b0; mw[0] = 1'b0;

      // W=2 instance
      do_op(1, 0, 1, 3'b010, 32'h40, 32'h0BADF00D, 32'h0, 0, "w2_sw40");
      do_op(1, 1, 0, 3'b010, 32'h40, 32'h0, 32'h0BADF00D, 0, "w2_lw40");
      do_op(1, 1, 0, 3'b101, 32'h42, 32'h0, 32'h00000BAD, 0, "w2_lhu42");
      do_op(1, 1, 0, 3'b000, 32'h43, 32'h0, 32'h0000000B, 0, "w2_lb43");
      do_op(1, 0, 0, 3'b000, 32'hCAFE0000, 32'h0, 32'h0, 0, "w2_nop");
      mr[1] = 1'b0; mw[1] = 1'b0;

      // W=3 instance: reset during the second stall cycle aborts the store
      do_op(2, 0, 1, 3'b010, 32'h20, 32'h11223344, 32'h0, 0, "w3_pre");
      f3[2] = 3'b010; mw[2] = 1'b1; mr[2] = 1'b0; wen[2] = 1'b0; dsel[2] = 1'b0;
      jal[2] = 32'h20; rd2[2] = 32'hCAFEBABE; rdx[2] = 5'd9;
      #1;
      check("abort/stall1", 32'(o_stall[2]), 32'd1);
      @(posedge clk);
      #1;
      check("abort/stall2", 32'(o_stall[2]), 32'd1);
      rst[2] = 1'b0;
      @(posedge clk);
      #1;
      check("abort/jal", o_jal[2], 32'd0);
      check("abort/rd", 32'(o_rd[2]), 32'd0);
      check("abort/f3", 32'(o_f3[2]), 32'd0);
      mw[2] = 1'b0;
      rst[2] = 1'b1;
      @(posedge clk);
      #1;
      do_op(2, 1, 0, 3'b010, 32'h20, 32'h0, 32'h11223344, 0, "w3_lw20");
      mr[2] = 1'b0;

      if (sb_q.size() != 0) check("sb_leftover", 32'(sb_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised pipeline MEM stage for the RV32IM core, sitting between the EX/MEM and MEM/WB boundaries.
- Performs byte, half-word and word loads and stores, with sign or zero extension on loads, against an internal word-organised data memory.
- Supports a configurable number of memory wait states, signalled upstream through a stall handshake.
- Registers all control and data outputs for the WB stage.

## Interface
Parameters:
- DEPTH_WORDS, 256, memory depth in 32-bit words; power of two, ≥4.
- WAIT_STATES, 0, extra cycles per memory access; legal range 0–15.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RST  in  1  reset, synchronous, active-low.
- EX_FUNC3  in  3  load/store size and signedness.
- EX_WRITE_ENABLE  in  1  register writeback enable, piped through.
- EX_DATA_MEM_SELECT  in  1  WB mux select, piped through.
- EX_MEM_WRITE  in  1  store request.
- EX_MEM_READ  in  1  load request.
- EX_JAL_SELECTED  in  32  byte address for memory ops; result value otherwise.
- EX_READ_DATA2  in  32  store data.
- EX_RD  in  5  destination register.
- MEM_FUNC3  out  3  registered EX_FUNC3.
- MEM_WRITE_ENABLE  out  1  registered writeback enable.
- MEM_DATA_MEM_SELECT  out  1  registered mux select.
- MEM_JAL_SELECTED  out  32  registered EX_JAL_SELECTED.
- MEM_DATA_OUT  out  32  extended load data.
- MEM_RD  out  5  registered EX_RD.
- MEM_STALL  out  1  combinational; upstream holds all EX_* inputs stable while high.
- MEM_MISALIGN  out  1  registered misaligned-access flag.

## Operation
- **Request.** req = EX_MEM_READ | EX_MEM_WRITE.
  - If both are high, the write wins and MEM_DATA_OUT is 0.
- **Addressing.**
  - Word index is EX_JAL_SELECTED[log2(DEPTH_WORDS)+1:2]; upper bits are ignored, so out-of-range addresses wrap.
  - Byte lane is addr[1:0]; little-endian.
- **Loads.** Selected by FUNC3:
  - LB 000: sign-extended byte.
  - LH 001: sign-extended half-word.
  - LW 010: full word.
  - LBU 100: zero-extended byte.
  - LHU 101: zero-extended half-word.
  - Other codes return 0.
- **Stores.** Selected by FUNC3:
  - SB 000: writes only the addressed byte.
  - SH 001: writes only the addressed half-word.
  - SW 010: writes the full word.
  - Other codes perform no write.
  - Unwritten lanes are preserved.
- **Non-memory ops.** When req=0, MEM_DATA_OUT=0 and all other fields pass through with 1-cycle latency.
- **FSM states:** IDLE, BUSY. Wait counter cnt is 4 bits.
  - IDLE & req & WAIT_STATES>0 → BUSY, cnt=1.
  - BUSY & cnt<WAIT_STATES → cnt+1.
  - BUSY & cnt==WAIT_STATES → IDLE, cnt=0.
  - MEM_STALL = req & WAIT_STATES>0 & !(BUSY & cnt==WAIT_STATES).
- **Completion edge.** The access completes on the first edge where req=1 and MEM_STALL=0. On that edge only:
  - the array write is performed, exactly once;
  - read data is captured;
  - all output registers update.
- **While stalled,** the output registers hold their values.

## Timing
- Reset:
  - All outputs are 0, state is IDLE, cnt is 0.
  - Memory contents are not reset.
- Latency:
  - With WAIT_STATES=W, an access presented at cycle n completes at the edge ending cycle n+W.
  - MEM_STALL is high for exactly W cycles.
  - With W=0 there is no stall and a 1-cycle register latency.
- Back-to-back accesses with W>0: the next request starts in IDLE on the cycle after completion, so there is no bubble beyond the W stall cycles.
- Reset asserted during BUSY:
  - The FSM aborts to IDLE and no write is committed.
  - Outputs are 0 on the next edge.
- Requests with the same address and W=0: a store followed by a load on the next cycle returns the new data, because the write-first array is written at the completion edge and read one cycle later.

## Configuration
- MEM_MISALIGN_TRAP_EN defined:
  - A misaligned access is LH/LHU/SH with addr[0]≠0, or LW/SW with addr[1:0]≠0.
  - A misaligned access completes with no wait states.
  - MEM_MISALIGN=1; the write is suppressed.
  - MEM_DATA_OUT=0 and MEM_WRITE_ENABLE is forced to 0.
- Undefined:
  - The offending low address bits are cleared, aligning the access.
  - MEM_MISALIGN is tied to 0.

## Structure
- Package mem_pkg holds the FUNC3 load/store localparams and the IDLE/BUSY state encoding.
- Sub-module data_mem_array holds the storage:
  - DEPTH_WORDS×32 array with 4-bit byte-enable synchronous write and combinational read.
  - Instantiated once.
- Extension logic, FSM and pipeline registers live in mem_access_unit.

## Test plan
- **Word store/load, W=0:** SW 0xDEADBEEF @0x18, then LW @0x18 → MEM_DATA_OUT=0xDEADBEEF one cycle later, MEM_STALL never high.
- **Byte lanes:** SB 0x000000EF @0x11 into a zeroed word.
  - LB @0x11 → 0xFFFFFFEF.
  - LBU @0x11 → 0x000000EF.
  - LW @0x10 → 0x0000EF00.
- **Half-word:** SH 0x00C0BEEF @0x16.
  - LH @0x16 → 0xFFFFBEEF.
  - LHU @0x16 → 0x0000BEEF.
  - LW @0x14 → 0xBEEF0000.
- **Wait states, WAIT_STATES=2:**
  - LW request → MEM_STALL high for 2 cycles; data valid after the 3rd edge.
  - SW → exactly one array write.
- **Misalign:** LW @0x1A.
  - With MEM_MISALIGN_TRAP_EN → MEM_MISALIGN=1, MEM_WRITE_ENABLE=0, data 0.
  - Without → returns the word at 0x18.
- **Reset abort, W=3:** RST low during the 2nd stall cycle of SW 0xCAFEBABE @0x20 → outputs 0 next edge; subsequent LW @0x20 returns the old value.
